regfile_wb_sched: RTL and testbench

Write-back scheduler and scoreboard for the integer register file. It shares the file's single write port among NUM_REQ result producers (ALU pipe, LSU, multi-cycle MDU) through valid/ready arbitration with anti-starvation aging. It also tracks pending destination registers and stalls the ID-stage issue on RAW and WAW hazards. It sits between the execution units and the register file write port, alongside ID.

---
 rtl/regfile_wb_sched.sv | 144 ++++++++++++++
 tb/tb_regfile_wb_sched.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the integer register file: arbitrates NUM_REQ result
// producers onto the single write port and tracks pending destinations for ID hazard stalls.
module regfile_wb_sched #(
    parameter int NUM_REQ   = 3,
    parameter int AGE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    input  logic [NUM_REQ*5-1:0]  i_req_addr,
    input  logic [NUM_REQ*32-1:0] i_req_data,
    output logic [NUM_REQ-1:0]    o_req_ready,
    input  logic                  i_iss_valid,
    input  logic [4:0]            i_iss_rs1,
    input  logic [4:0]            i_iss_rs2,
    input  logic [4:0]            i_iss_rd,
    input  logic                  i_iss_rs1_en,
    input  logic                  i_iss_rs2_en,
    input  logic                  i_iss_rd_en,
    output logic                  o_iss_stall,
    input  logic                  i_flush,
    output logic                  o_wr_en,
    output logic [4:0]            o_wr_addr,
    output logic [31:0]           o_wr_data,
    output logic [31:0]           o_busy
);

    localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);

    logic [3:0]         r_age [NUM_REQ];
    logic [NUM_REQ-1:0] w_grant;
    logic [4:0]         w_sel_addr;
    logic [31:0]        w_sel_data;
    logic               w_write;

    logic               r_wr_en;
    logic [4:0]         r_wr_addr;
    logic [31:0]        r_wr_data;
    logic [31:0]        r_busy;
    logic [31:0]        w_wr_clr;
    logic [31:0]        w_set;
    logic [31:0]        w_pend;
    logic               w_raw_a;
    logic               w_raw_b;
    logic               w_waw;
    logic               w_stall;
    logic               w_iss_fire;

    // Starved requesters first, then plain fixed priority; index 0 wins ties.
    always_comb begin
        logic found;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        w_grant = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && i_req_valid[i] && r_age[i] == AGE_MAX) begin
                w_grant[i] = 1'b1;
                found      = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && i_req_valid[i]) begin
                w_grant[i] = 1'b1;
                found      = 1'b1;
            end
        end
        if (!rst_n) begin
            w_grant = '0;
        end
    end

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = i_req_addr[5*i +: 5];
                w_sel_data = i_req_data[32*i +: 32];
            end
        end
    end

    // A grant to x0 is consumed but never reaches the register file.
    assign w_write = (|w_grant) && (w_sel_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!i_req_valid[i] || w_grant[i]) begin
                    r_age[i] <= '0;
                end else if (r_age[i] != AGE_MAX) begin
                    r_age[i] <= r_age[i] + 4'd1;
                end
            end
        end
    end

    // Address and data only move on a real write; otherwise they hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_write;
            if (w_write) begin
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
            end
        end
    end

    // The register being written this cycle is readable through the file's bypass.
    assign w_wr_clr = r_wr_en ? (32'd1 << r_wr_addr) : 32'd0;
    assign w_pend   = r_busy & ~w_wr_clr;

    assign w_raw_a    = i_iss_rs1_en && (i_iss_rs1 != 5'd0) && w_pend[i_iss_rs1];
    assign w_raw_b    = i_iss_rs2_en && (i_iss_rs2 != 5'd0) && w_pend[i_iss_rs2];
    assign w_waw      = i_iss_rd_en  && (i_iss_rd  != 5'd0) && w_pend[i_iss_rd];
    assign w_stall    = rst_n && i_iss_valid && (w_raw_a || w_raw_b || w_waw);
    assign w_iss_fire = i_iss_valid && !w_stall;
    assign w_set      = (w_iss_fire && i_iss_rd_en && i_iss_rd != 5'd0) ? (32'd1 << i_iss_rd) : 32'd0;

    // Set is applied after clear so a newly issued producer stays pending; flush overrides both.
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_wr_clr) | w_set) & 32'hFFFF_FFFE;
        end
    end

    assign o_req_ready = w_grant;
    assign o_iss_stall = w_stall;
    assign o_wr_en     = r_wr_en;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: grants are checked per cycle against hand-written
// rows, expected writes are queued and popped by an independent write-port monitor.
module tb_regfile_wb_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   req_valid;
    logic [14:0]  req_addr;
    logic [95:0]  req_data;
    logic [2:0]   req_ready;
    logic         iss_valid;
    logic [4:0]   iss_rs1, iss_rs2, iss_rd;
    logic         iss_rs1_en, iss_rs2_en, iss_rd_en;
    logic         iss_stall;
    logic         flush;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic [31:0]  busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_exp_t;

    typedef struct {
        logic [2:0]  v;
        logic [14:0] a;
        logic [95:0] d;
        logic [2:0]  rdy;
    } arb_row_t;

    wr_exp_t  exp_q[$];
    arb_row_t arb_q[$];

    regfile_wb_sched #(.NUM_REQ(3), .AGE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_data(req_data),
        .o_req_ready(req_ready),
        .i_iss_valid(iss_valid), .i_iss_rs1(iss_rs1), .i_iss_rs2(iss_rs2), .i_iss_rd(iss_rd),
        .i_iss_rs1_en(iss_rs1_en), .i_iss_rs2_en(iss_rs2_en), .i_iss_rd_en(iss_rd_en),
        .o_iss_stall(iss_stall), .i_flush(flush),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_iss(input logic v, input logic [4:0] rs1, input logic rs1_en,
                           input logic [4:0] rs2, input logic rs2_en,
                           input logic [4:0] rd, input logic rd_en);
        iss_valid  = v;
        iss_rs1    = rs1;  iss_rs1_en = rs1_en;
        iss_rs2    = rs2;  iss_rs2_en = rs2_en;
        iss_rd     = rd;   iss_rd_en  = rd_en;
    endtask

    // Checks the grant and, for a non-x0 winner, queues the write due next cycle.
    task automatic expect_ready(input string name, input logic [2:0] exp);
        wr_exp_t e;
        check(name, {29'd0, req_ready}, {29'd0, exp});
        for (int i = 0; i < 3; i++) begin
            if (exp[i] && req_addr[5*i +: 5] != 5'd0) begin
                e.cyc  = cyc + 1;
                e.addr = req_addr[5*i +: 5];
                e.data = req_data[32*i +: 32];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic add_row(input logic [2:0] v, input logic [14:0] a,
                           input logic [95:0] d, input logic [2:0] rdy);
        arb_row_t r;
        r.v = v; r.a = a; r.d = d; r.rdy = rdy;
        arb_q.push_back(r);
    endtask

    task automatic run_arb(input string name);
        arb_row_t r;
        while (arb_q.size() > 0) begin
            r = arb_q.pop_front();
            next_cycle();
            req_valid = r.v;
            req_addr  = r.a;
            req_data  = r.d;
            sample();
            expect_ready(name, r.rdy);
        end
    endtask

    // Write-port monitor: every wr_en must match the oldest queued expectation.
    always @(negedge clk) begin
        wr_exp_t e;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wr_unexpected: got write x%0d=%0h, expected none (cycle %0d)",
                         wr_addr, wr_data, cyc);
            end else begin
                e = exp_q.pop_front();
                check("wr_cycle", cyc, e.cyc);
                check("wr_addr", {27'd0, wr_addr}, {27'd0, e.addr});
                check("wr_data", wr_data, e.data);
            end
        end
    end

    initial begin
        flush     = 1'b0;
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = {32'h33, 32'h22, 32'h11};
        set_iss(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);

        // Reset with everything requesting
        repeat (2) next_cycle();
        sample();
        check("rst_ready", {29'd0, req_ready}, 32'd0);
        check("rst_stall", {31'd0, iss_stall}, 32'd0);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);

        next_cycle();
        rst_n = 1'b1;
        set_iss(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        sample();
        expect_ready("rel_ready", 3'b001);

        // Priority, back-to-back, mixed, x0 grant
        add_row(3'b000, 15'd0, 96'd0, 3'b000);
        add_row(3'b101, {5'd6, 5'd0, 5'd5}, {32'h1234, 32'h0, 32'hAAAA}, 3'b001);
        add_row(3'b100, {5'd6, 5'd0, 5'd5}, {32'h1234, 32'h0, 32'hAAAA}, 3'b100);
        add_row(3'b110, {5'd9, 5'd8, 5'd0}, {32'h99, 32'h88, 32'h0}, 3'b010);
        add_row(3'b100, {5'd9, 5'd8, 5'd0}, {32'h99, 32'h88, 32'h0}, 3'b100);
        add_row(3'b001, 15'd0, {32'h0, 32'h0, 32'hDEAD}, 3'b001);
        add_row(3'b000, 15'd0, 96'd0, 3'b000);
        run_arb("prio_ready");

        // Starvation: req2 starts at s0, req1 at s1; AGE_LIMIT=4
        add_row(3'b101, {5'd12, 5'd11, 5'd10}, {32'h300, 32'h200, 32'h100}, 3'b001);
        add_row(3'b111, {5'd12, 5'd11, 5'd10}, {32'h300, 32'h200, 32'h100}, 3'b001);
        add_row(3'b111, {5'd12, 5'd11, 5'd10}, {32'h300, 32'h200, 32'h100}, 3'b001);
        add_row(3'b111, {5'd12, 5'd11, 5'd10}, {32'h300, 32'h200, 32'h100}, 3'b001);
        add_row(3'b111, {5'd12, 5'd11, 5'd10}, {32'h300, 32'h200, 32'h100}, 3'b100);
        add_row(3'b111, {5'd13, 5'd11, 5'd10}, {32'h301, 32'h200, 32'h100}, 3'b010);
        add_row(3'b101, {5'd13, 5'd11, 5'd10}, {32'h301, 32'h200, 32'h100}, 3'b001);
        add_row(3'b101, {5'd13, 5'd11, 5'd10}, {32'h301, 32'h200, 32'h100}, 3'b001);
        add_row(3'b101, {5'd13, 5'd11, 5'd10}, {32'h301, 32'h200, 32'h100}, 3'b001);
        add_row(3'b101, {5'd13, 5'd11, 5'd10}, {32'h301, 32'h200, 32'h100}, 3'b100);
        add_row(3'b000, 15'd0, 96'd0, 3'b000);
        run_arb("starve_ready");

        // RAW on x7 released by the write-cycle bypass
        next_cycle();
        set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        sample();
        check("raw_issue_stall", {31'd0, iss_stall}, 32'd0);
        next_cycle();
        set_iss(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        sample();
        check("raw_stall", {31'd0, iss_stall}, 32'd1);
        check("raw_busy", busy, 32'h80);
        next_cycle();
        req_valid = 3'b010; req_addr = {5'd0, 5'd7, 5'd0}; req_data = {32'h0, 32'h77, 32'h0};
        sample();
        check("raw_stall_wait", {31'd0, iss_stall}, 32'd1);
        expect_ready("raw_grant", 3'b010);
        next_cycle();
        req_valid = 3'b000;
        sample();
        check("raw_bypass_stall", {31'd0, iss_stall}, 32'd0);
        next_cycle();
        set_iss(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        sample();
        check("raw_busy_clear", busy, 32'd0);

        // x0 destination, x0 grant, WAW and operand enables
        next_cycle();
        set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        req_valid = 3'b001; req_addr = 15'd0; req_data = {32'h0, 32'h0, 32'hBEEF};
        sample();
        check("x0_issue_stall", {31'd0, iss_stall}, 32'd0);
        expect_ready("x0_grant", 3'b001);
        next_cycle();
        req_valid = 3'b000;
        set_iss(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        sample();
        check("x0_busy", busy, 32'd0);
        check("x0_no_write", {31'd0, wr_en}, 32'd0);
        next_cycle();
        set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        sample();
        check("waw_first_stall", {31'd0, iss_stall}, 32'd0);
        next_cycle();
        sample();
        check("waw_stall", {31'd0, iss_stall}, 32'd1);
        check("waw_busy", busy, 32'h200);
        next_cycle();
        set_iss(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
        sample();
        check("rawb_stall", {31'd0, iss_stall}, 32'd1);
        next_cycle();
        set_iss(1'b1, 5'd9, 1'b0, 5'd9, 1'b0, 5'd9, 1'b0);
        sample();
        check("en_low_stall", {31'd0, iss_stall}, 32'd0);
        next_cycle();
        set_iss(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        sample();
        check("iss_invalid_stall", {31'd0, iss_stall}, 32'd0);

        // Same-cycle set and clear on x3, then again with flush
        next_cycle();
        set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        sample();
        check("sim_issue_stall", {31'd0, iss_stall}, 32'd0);
        next_cycle();
        set_iss(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        req_valid = 3'b001; req_addr = {5'd0, 5'd0, 5'd3}; req_data = {32'h0, 32'h0, 32'h33};
        sample();
        expect_ready("sim_grant", 3'b001);
        check("sim_busy_pre", busy, 32'h208);
        next_cycle();
        req_valid = 3'b000;
        set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        sample();
        check("sim_bypass_stall", {31'd0, iss_stall}, 32'd0);
        next_cycle();
        set_iss(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        sample();
        check("sim_set_wins", busy, 32'h208);
        next_cycle();
        req_valid = 3'b001; req_addr = {5'd0, 5'd0, 5'd3}; req_data = {32'h0, 32'h0, 32'h34};
        sample();
        expect_ready("flush_grant", 3'b001);
        next_cycle();
        req_valid = 3'b000;
        set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        flush = 1'b1;
        sample();
        check("flush_stall", {31'd0, iss_stall}, 32'd0);
        next_cycle();
        flush = 1'b0;
        set_iss(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        sample();
        check("flush_busy", busy, 32'd0);

        // Reset mid-operation drops busy bits and the grant of the reset cycle
        next_cycle();
        set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1);
        sample();
        check("mid_issue_stall", {31'd0, iss_stall}, 32'd0);
        next_cycle();
        set_iss(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        rst_n = 1'b0;
        req_valid = 3'b001; req_addr = {5'd0, 5'd0, 5'd11}; req_data = {32'h0, 32'h0, 32'hBB};
        sample();
        check("mid_rst_ready", {29'd0, req_ready}, 32'd0);
        check("mid_busy_pre", busy, 32'h400);
        next_cycle();
        rst_n = 1'b1;
        req_valid = 3'b000;
        sample();
        check("mid_busy", busy, 32'd0);
        check("mid_wr_en", {31'd0, wr_en}, 32'd0);
        check("mid_wr_addr", {27'd0, wr_addr}, 32'd0);
        check("mid_wr_data", wr_data, 32'd0);
        next_cycle();
        req_valid = 3'b001; req_addr = {5'd0, 5'd0, 5'd12}; req_data = {32'h0, 32'h0, 32'hCC};
        sample();
        expect_ready("post_rst_grant", 3'b001);
        next_cycle();
        req_valid = 3'b000;
        sample();
        repeat (2) next_cycle();
        sample();

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL wr_missing: got %0d writes outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
